// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 11-bit frame, device ack check.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a transfer when the device stops clocking.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_OK,
  output logic       ERR
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE} state_t;
  state_t state, state_nxt;

  // clk_sync[1] is the synchronized line, clk_sync[2] its previous value
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [IW-1:0] inh_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;
  logic          bit_oe;
  logic          fall;
  logic          load;
  logic          sample;

  assign fall = clk_sync[2] & ~clk_sync[1];
  assign BUSY = (state != IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_active;
  logic          timeout;

  assign wd_active = (state == RTS) || (state == SHIFT) || (state == ACK) || (state == RELEASE);
  assign timeout   = wd_active && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            wd_cnt <= '0;
    else if (wd_active) wd_cnt <= wd_cnt + TW'(1);
    else                wd_cnt <= '0;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    PS2CLK_OE  = 1'b0;
    PS2DATA_OE = 1'b0;
    DONE       = 1'b0;
    load       = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (WR_EN) begin
          load      = 1'b1;
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        PS2CLK_OE = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          PS2DATA_OE = 1'b1;
          state_nxt  = RTS;
        end
      end
      RTS: begin
        PS2DATA_OE = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        PS2DATA_OE = bit_oe;
        if (fall && bit_idx == 4'd9) state_nxt = ACK;
      end
      ACK: begin
        if (fall) begin
          sample    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (clk_sync[1] && dat_sync[1]) begin
          DONE      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (timeout) begin
      PS2CLK_OE  = 1'b0;
      PS2DATA_OE = 1'b0;
      DONE       = 1'b1;
      sample     = 1'b0;
      state_nxt  = IDLE;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_sync <= '1;
      dat_sync <= '1;
      inh_cnt  <= '0;
      bit_idx  <= '0;
      frame    <= '0;
      bit_oe   <= 1'b0;
      ACK_OK   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], PS2CLK_IN};
      dat_sync <= {dat_sync[0], PS2DATA_IN};

      if (state == INHIBIT) inh_cnt <= inh_cnt + IW'(1);
      else                  inh_cnt <= '0;

      // frame holds {stop, odd parity, D7..D0}; D0 goes out first
      if (load) begin
        frame  <= {1'b1, ~^WR_DATA, WR_DATA};
        ACK_OK <= 1'b0;
        ERR    <= 1'b0;
      end

      if (state == RTS) begin
        bit_idx <= '0;
        bit_oe  <= 1'b1;
      end else if (state == SHIFT && fall) begin
        bit_oe  <= ~frame[0];
        frame   <= {1'b1, frame[9:1]};
        bit_idx <= bit_idx + 4'd1;
      end

      if (sample) begin
        ACK_OK <= ~dat_sync[1];
        ERR    <= dat_sync[1];
      end
`ifdef PS2_TX_TIMEOUT_EN
      if (timeout) begin
        ACK_OK <= 1'b0;
        ERR    <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain wire model, device clock/ack model, table vectors and random transfers.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 1000;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       PS2CLK_IN, PS2DATA_IN, PS2CLK_OE, PS2DATA_OE, BUSY, DONE, ACK_OK, ERR;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;

  assign PS2CLK_IN  = dev_clk & ~PS2CLK_OE;
  assign PS2DATA_IN = dev_dat & ~PS2DATA_OE;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .PS2CLK_IN(PS2CLK_IN), .PS2DATA_IN(PS2DATA_IN),
    .PS2CLK_OE(PS2CLK_OE), .PS2DATA_OE(PS2DATA_OE),
    .BUSY(BUSY), .DONE(DONE), .ACK_OK(ACK_OK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0]  d;
    bit          ack;
    bit          inject;
    logic [10:0] exp_frame;
    bit          exp_ok;
    bit          exp_err;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Device side of one host->device transfer; returns what the wire carried.
  task automatic do_transfer(input logic [7:0] d, input bit ack, input bit inject, input int half,
                             output int inh_len, output int dat_pos, output logic [10:0] fr);
    int n;
    inh_len = 0;
    dat_pos = -1;
    fr      = '0;
    WR_DATA = d;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;
    n = 0;
    while (PS2CLK_OE !== 1'b0 && n < INH + 50) begin
      if (PS2DATA_OE === 1'b1 && dat_pos < 0) dat_pos = inh_len;
      inh_len++;
      if (inject && inh_len == 3) begin
        WR_DATA = 8'hFF;
        WR_EN   = 1'b1;
      end else begin
        WR_EN = 1'b0;
      end
      tick();
      n++;
    end
    WR_EN   = 1'b0;
    WR_DATA = 8'h00;
    repeat (4) tick();
    fr[0] = PS2DATA_IN;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (half) tick();
      fr[i] = PS2DATA_IN;
      dev_clk = 1'b1;
      repeat (half) tick();
    end
    dev_dat = ~ack;
    repeat (2) tick();
    dev_clk = 1'b0;
    repeat (half) tick();
    dev_clk = 1'b1;
    repeat (half) tick();
    dev_dat = 1'b1;
    n = 0;
    while (BUSY !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [7:0] d, input bit ack, input bit inject,
                           input int half, input logic [10:0] ef, input bit eok, input bit eerr);
    int il, dp, d0;
    logic [10:0] fr;
    d0 = done_cnt;
    do_transfer(d, ack, inject, half, il, dp, fr);
    check({tag, " inhibit_len"}, il, INH);
    check({tag, " data_oe_pos"}, dp, INH - 1);
    check({tag, " frame"}, {21'd0, fr}, {21'd0, ef});
    check({tag, " ack_ok"}, {31'd0, ACK_OK}, {31'd0, eok});
    check({tag, " err"}, {31'd0, ERR}, {31'd0, eerr});
    check({tag, " done_pulses"}, done_cnt - d0, 1);
    check({tag, " idle_lines"}, {30'd0, PS2CLK_OE, PS2DATA_OE}, 32'd0);
    check({tag, " busy_low"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    vec_t vecs[3];
    logic [7:0] rd;
    bit ra;
    int n, d0;

    vecs[0] = '{8'hF4, 1'b1, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 1'b0};
    vecs[1] = '{8'hED, 1'b0, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0};

    repeat (3) tick();
    check("reset clk_oe", {31'd0, PS2CLK_OE}, 32'd0);
    check("reset data_oe", {31'd0, PS2DATA_OE}, 32'd0);
    check("reset busy", {31'd0, BUSY}, 32'd0);
    check("reset done", {31'd0, DONE}, 32'd0);
    check("reset ack_ok", {31'd0, ACK_OK}, 32'd0);
    check("reset err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 3; v++)
      run_check($sformatf("vec%0d", v), vecs[v].d, vecs[v].ack, vecs[v].inject, HALF,
                vecs[v].exp_frame, vecs[v].exp_ok, vecs[v].exp_err);

    // Reference model: start 0, data LSB first, parity making the ones count odd, stop 1.
    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      run_check($sformatf("rnd%0d", r), rd, ra, 1'b0, int'($urandom_range(5, 10)),
                {1'b1, 1'($countones(rd) % 2 == 0), rd, 1'b0}, ra, !ra);
    end

    // Abort after the 4th device clock falling edge.
    WR_DATA = 8'h55;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
    n = 0;
    while (PS2CLK_OE !== 1'b0 && n < INH + 50) begin
      tick();
      n++;
    end
    repeat (4) tick();
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (i < 4) begin
        dev_clk = 1'b1;
        repeat (HALF) tick();
      end
    end
    check("abort pre busy", {31'd0, BUSY}, 32'd1);
    check("abort pre data_oe (D3=0)", {31'd0, PS2DATA_OE}, 32'd1);
    d0  = done_cnt;
    RST = 1'b1;
    #1;
    check("abort lines", {30'd0, PS2CLK_OE, PS2DATA_OE}, 32'd0);
    check("abort busy", {31'd0, BUSY}, 32'd0);
    dev_clk = 1'b1;
    repeat (5) tick();
    RST = 1'b0;
    repeat (5) tick();
    check("abort no done", done_cnt - d0, 0);
    run_check("post_abort", 8'hF4, 1'b1, 1'b0, HALF, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    d0 = done_cnt;
    WR_DATA = 8'hF4;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
    n = 0;
    while (PS2CLK_OE !== 1'b0 && n < INH + 50) begin
      tick();
      n++;
    end
    n = 0;
    while (DONE !== 1'b1 && n < TO + 50) begin
      tick();
      n++;
    end
    check("timeout cycles", n + 1, TO);
    tick();
    check("timeout err", {31'd0, ERR}, 32'd1);
    check("timeout ack_ok", {31'd0, ACK_OK}, 32'd0);
    check("timeout lines", {30'd0, PS2CLK_OE, PS2DATA_OE}, 32'd0);
    check("timeout busy", {31'd0, BUSY}, 32'd0);
    check("timeout done pulses", done_cnt - d0, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
